vga_fb_reader: RTL and testbench

VGA_FB_READER -- requirements
Module: vga_fb_reader

---
 rtl/vga_fb_pkg.sv | 41 ++++
 rtl/vga_timing.sv | 61 ++++++
 rtl/vga_fb_reader.sv | 153 +++++++++++++++
 tb/tb_vga_fb_reader.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared constants and types for the VGA framebuffer reader.
//   - 640x480@60 timing constants (visible, front porch, sync, back porch, total)
//   - framebuffer geometry (WORDS_PER_ROW, PIX_PER_WORD)
//   - rgb444_t colour type and the fixed 16-entry palette
// No ports; imported by vga_timing and vga_fb_reader.
package vga_fb_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;  // 800

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;  // 525

  localparam int WORDS_PER_ROW = 20;
  localparam int PIX_PER_WORD  = 8;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Element [0] is the rightmost literal, so index 0 is black.
  localparam logic [15:0][11:0] PALETTE = {
    12'hFFF, 12'hFF5, 12'hF5F, 12'hF55,
    12'h5FF, 12'h5F5, 12'h55F, 12'h555,
    12'hAAA, 12'hA50, 12'hA0A, 12'hA00,
    12'h0AA, 12'h0A0, 12'h00A, 12'h000
  };

  function automatic rgb444_t palette_lookup(input logic [3:0] idx);
    return rgb444_t'(PALETTE[idx]);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel-tick divider plus 800x525 raster counters.
// Ports:
//   clk, reset    - single clock, synchronous active-high reset
//   tick          - one-clk strobe every CLK_DIV clks; h/v advance on it
//   h, v          - current raster position (h 0..799, v 0..524)
//   hsync_n       - combinational active-low HS decode for the current h
//   vsync_n       - combinational active-low VS decode for the current v
//   visible       - current h/v is inside the 640x480 active area
//   frame_start   - registered one-clk pulse for the tick at h=0, v=0; it
//                   lines up with the registered colour of that pixel
module vga_timing
  import vga_fb_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic       tick,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       visible,
  output logic       frame_start
);

  logic [3:0] div;

  assign tick = (div == 4'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      div         <= 4'd0;
      h           <= 10'd0;
      v           <= 10'd0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && (h == 10'd0) && (v == 10'd0);
      if (tick) begin
        div <= 4'd0;
        if (h == 10'(H_TOTAL - 1)) begin
          h <= 10'd0;
          v <= (v == 10'(V_TOTAL - 1)) ? 10'd0 : v + 10'd1;
        end else begin
          h <= h + 10'd1;
        end
      end else begin
        div <= div + 4'd1;
      end
    end
  end

  always_comb begin
    hsync_n = !((h >= 10'(H_VISIBLE + H_FRONT)) &&
                (h <  10'(H_VISIBLE + H_FRONT + H_SYNC)));
    vsync_n = !((v >= 10'(V_VISIBLE + V_FRONT)) &&
                (v <  10'(V_VISIBLE + V_FRONT + V_SYNC)));
    visible = (h < 10'(H_VISIBLE)) && (v < 10'(V_VISIBLE));
  end

endmodule

// File: rtl/vga_fb_reader.sv
// vga_fb_reader: scans a 160x120, 4-bit-indexed framebuffer out of data
// memory through a read-only io port and drives a 640x480 VGA output.
// Each framebuffer pixel covers a 4x4 block of VGA pixels.
// Ports:
//   clk, reset          - single clock, synchronous active-high reset
//   test_mode           - only with VGA_FB_TESTPATTERN_EN: vertical colour
//                         bars from h[9:6], no memory fetches
//   wEn, memDataIn      - memory write side, tied to 0
//   addr                - memory word address, held between fetches
//   memDataOut          - read data, valid one clk after addr
//   VGA_R/G/B           - registered RGB444, forced 0 in blanking
//   VGA_HS/VGA_VS       - registered active-low syncs
//   frame_start         - one-clk pulse with the colour of pixel (0,0)
// Build option: define VGA_FB_TESTPATTERN_EN to add the test_mode port.
module vga_fb_reader
  import vga_fb_pkg::*;
#(
  parameter int          CLK_DIV = 4,
  parameter logic [11:0] FB_BASE = 12'h600
) (
  input  logic        clk,
  input  logic        reset,
`ifdef VGA_FB_TESTPATTERN_EN
  input  logic        test_mode,
`endif
  output logic        wEn,
  output logic [11:0] addr,
  output logic [31:0] memDataIn,
  input  logic [31:0] memDataOut,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        frame_start
);

  logic        tick;
  logic [9:0]  h;
  logic [9:0]  v;
  logic        hsync_n;
  logic        vsync_n;
  logic        visible;

  logic [31:0] cur;
  logic [31:0] nxt;
  logic [31:0] word_sel;
  logic [3:0]  pix_idx;
  logic        fetch_pix;
  logic        fetch_row;
  logic        fetch_p1;
  logic        fetch_p2;
  logic [7:0]  row_next;
  logic [11:0] addr_next;
  rgb444_t     rgb_q;

  vga_timing #(
    .CLK_DIV (CLK_DIV)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .h           (h),
    .v           (v),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .visible     (visible),
    .frame_start (frame_start)
  );

  assign wEn       = 1'b0;
  assign memDataIn = 32'd0;
  assign VGA_R     = rgb_q.r;
  assign VGA_G     = rgb_q.g;
  assign VGA_B     = rgb_q.b;

  always_comb begin
    // At the start of each 32-pixel word span, prefetch the following word.
    // The last word of a row has no successor, so h=608 issues nothing.
    fetch_pix = tick && visible && (h[4:0] == 5'd0) &&
                (h != 10'((WORDS_PER_ROW - 1) * 32));
    // At the end of every line, preload word 0 of the row the next line
    // shows (wrapping from line 524 to row 0).
    fetch_row = tick && (h == 10'(H_TOTAL - 1)) &&
                ((v < 10'(V_VISIBLE - 1)) || (v == 10'(V_TOTAL - 1)));
`ifdef VGA_FB_TESTPATTERN_EN
    if (test_mode) begin
      fetch_pix = 1'b0;
      fetch_row = 1'b0;
    end
`endif

    // Framebuffer row of line v+1: (v+1)>>2, with 524 wrapping to 0.
    row_next = v[9:2] + {7'd0, &v[1:0]};
    if (v == 10'(V_TOTAL - 1)) begin
      row_next = 8'd0;
    end

    if (fetch_row) begin
      addr_next = FB_BASE + {4'd0, row_next} * 12'(WORDS_PER_ROW);
    end else begin
      addr_next = FB_BASE + {4'd0, v[9:2]} * 12'(WORDS_PER_ROW) +
                  {7'd0, h[9:5]} + 12'd1;
    end

    // On a word boundary the new word is taken from nxt; if its read data
    // is arriving on this very clk (only possible with CLK_DIV=2), bypass
    // the capture register and use memDataOut directly.
    word_sel = cur;
    if (h[4:0] == 5'd0) begin
      word_sel = fetch_p2 ? memDataOut : nxt;
    end
    pix_idx = word_sel[{h[4:2], 2'b00} +: 4];
`ifdef VGA_FB_TESTPATTERN_EN
    if (test_mode) begin
      pix_idx = h[9:6];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur      <= 32'd0;
      nxt      <= 32'd0;
      fetch_p1 <= 1'b0;
      fetch_p2 <= 1'b0;
      addr     <= FB_BASE;
      rgb_q    <= '0;
      VGA_HS   <= 1'b1;
      VGA_VS   <= 1'b1;
    end else begin
      // addr is registered on the fetch tick; read data is valid one clk
      // later and is captured into nxt on the clk after that.
      fetch_p1 <= fetch_pix || fetch_row;
      fetch_p2 <= fetch_p1;
      if (fetch_p2) begin
        nxt <= memDataOut;
      end
      if (fetch_pix || fetch_row) begin
        addr <= addr_next;
      end
      if (tick) begin
        if (visible && (h[4:0] == 5'd0)) begin
          cur <= word_sel;
        end
        rgb_q  <= visible ? palette_lookup(pix_idx) : '0;
        VGA_HS <= hsync_n;
        VGA_VS <= vsync_n;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_reader.sv
// tb_vga_fb_reader: directed bench for vga_fb_reader with a synchronous
// memory model, a colour scoreboard for the preloaded words, and a raster
// model for sync, blanking, frame_start and the fetch address sequence.
module tb_vga_fb_reader;

  localparam int          CLK_DIV = 4;
  localparam logic [11:0] FB      = 12'h600;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        wEn;
  logic [11:0] addr;
  logic [31:0] memDataIn;
  logic [31:0] memDataOut;
  logic [3:0]  VGA_R;
  logic [3:0]  VGA_G;
  logic [3:0]  VGA_B;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        frame_start;
`ifdef VGA_FB_TESTPATTERN_EN
  logic        test_mode = 1'b0;
`endif

  vga_fb_reader #(
    .CLK_DIV (CLK_DIV),
    .FB_BASE (FB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef VGA_FB_TESTPATTERN_EN
    .test_mode   (test_mode),
`endif
    .wEn         (wEn),
    .addr        (addr),
    .memDataIn   (memDataIn),
    .memDataOut  (memDataOut),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .frame_start (frame_start)
  );

  // synchronous data memory: read data valid one clk after addr
  logic [31:0] mem [4096];
  always @(posedge clk) memDataOut <= mem[addr];

  // scoreboard
  logic [11:0] exp_q[$];
  logic [11:0] pal [16];
  int total = 0;
  int bad   = 0;
  int cur_k = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, cur_k, obs, exp);
    end
  endtask

  function automatic logic [11:0] rgb_obs();
    return {VGA_R, VGA_G, VGA_B};
  endfunction

  task automatic check_reset_values();
    check("rst_rgb", 32'(rgb_obs()), 32'h0);
    check("rst_hs", 32'(VGA_HS), 32'h1);
    check("rst_vs", 32'(VGA_VS), 32'h1);
    check("rst_fs", 32'(frame_start), 32'h0);
    check("rst_addr", 32'(addr), 32'(FB));
    check("rst_wen", 32'(wEn), 32'h0);
  endtask

  initial begin
    int h_m;
    int v_m;
    int tmp;
    int n;
    bit found;
    logic [11:0] exp_addr;
    logic [11:0] exp_rgb;
    bit in_sb;

    pal[0]  = 12'h000; pal[1]  = 12'h00A; pal[2]  = 12'h0A0; pal[3]  = 12'h0AA;
    pal[4]  = 12'hA00; pal[5]  = 12'hA0A; pal[6]  = 12'hA50; pal[7]  = 12'hAAA;
    pal[8]  = 12'h555; pal[9]  = 12'h55F; pal[10] = 12'h5F5; pal[11] = 12'h5FF;
    pal[12] = 12'hF55; pal[13] = 12'hF5F; pal[14] = 12'hFF5; pal[15] = 12'hFFF;

    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;

    // preload and push expected colours in raster order
    mem[FB] = 32'h22222222;
    for (int i = 0; i < 32; i++) exp_q.push_back(pal[0]);       // line 0 word 0 not fetched yet
    mem[FB + 12'd1] = 32'h76543210;
    for (int i = 0; i < 32; i++) exp_q.push_back(pal[i / 4]);   // line 0 h 32..63
    for (int i = 0; i < 96; i++) exp_q.push_back(pal[2]);       // lines 1..3 h 0..31
    mem[FB + 12'd20] = 32'hFFFFFFFF;
    for (int i = 0; i < 128; i++) exp_q.push_back(pal[15]);     // lines 4..7 h 0..31

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();

    // scan: each iteration lands 1ns after the edge that registers pixel k
    @(negedge clk);
    reset = 1'b0;
    exp_addr = FB;
    for (int k = 0; k <= 10 * 800 + 300; k++) begin
      cur_k = k;
      repeat (CLK_DIV) @(posedge clk);
      #1;
      h_m = k % 800;
      v_m = (k / 800) % 525;

      if (v_m < 480 && h_m < 640 && (h_m % 32) == 0 && h_m != 608) begin
        tmp = 32'(FB) + (v_m / 4) * 20 + h_m / 32 + 1;
        exp_addr = 12'(tmp);
      end else if (h_m == 799 && (v_m < 479 || v_m == 524)) begin
        tmp = 32'(FB) + (((v_m + 1) % 525) / 4) * 20;
        exp_addr = 12'(tmp);
      end
      check("addr", 32'(addr), 32'(exp_addr));
      check("hs", 32'(VGA_HS), (h_m >= 656 && h_m <= 751) ? 32'h0 : 32'h1);
      check("vs", 32'(VGA_VS), (v_m >= 490 && v_m <= 491) ? 32'h0 : 32'h1);
      check("frame_start", 32'(frame_start), (k == 0) ? 32'h1 : 32'h0);
      check("wen", 32'(wEn), 32'h0);
      check("mem_data_in", memDataIn, 32'h0);

      in_sb = (v_m == 0 && h_m < 64) || (v_m >= 1 && v_m <= 7 && h_m < 32);
      if (in_sb) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'(exp_q.size()), 32'h1);
        end else begin
          exp_rgb = exp_q.pop_front();
          check("rgb_sb", 32'(rgb_obs()), 32'(exp_rgb));
        end
      end else if (h_m >= 640 || v_m >= 480) begin
        check("rgb_blank", 32'(rgb_obs()), 32'h0);
      end
    end
    check("sb_empty", 32'(exp_q.size()), 32'h0);

    // mid-frame reset at v=10, h=300 held for 3 clks
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_reset_values();
    end
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    found = 1'b0;
    while (!found && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (frame_start === 1'b1) found = 1'b1;
    end
    check("fs_after_reset", 32'(n), 32'(CLK_DIV));
    check("addr_after_reset", 32'(addr), 32'(FB + 12'd1));
    check("rgb_after_reset", 32'(rgb_obs()), 32'(pal[0]));
    @(posedge clk);
    #1;
    check("fs_one_clk", 32'(frame_start), 32'h0);

`ifdef VGA_FB_TESTPATTERN_EN
    // colour bars, no fetches
    @(negedge clk);
    reset = 1'b1;
    test_mode = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k <= 800; k++) begin
      cur_k = k;
      repeat (CLK_DIV) @(posedge clk);
      #1;
      h_m = k % 800;
      check("tp_rgb", 32'(rgb_obs()), (h_m < 640) ? 32'(pal[h_m / 64]) : 32'h0);
      check("tp_addr", 32'(addr), 32'(FB));
    end
    test_mode = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
